// File: rtl/instruction_fetch.sv
// instruction_fetch: IDLE/FETCH/HOLD instruction fetch unit with a valid/ready
// output, jump redirect, halt, and a program counter that wraps at PROG_LEN.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, halt                begin fetching at START_ADDR / stop fetching
//   jump_en, jump_addr         redirect the next fetch
//   mem_address, mem_enable    instruction memory request (address = PC)
//   mem_data                   combinational read data from memory
//   instr, instr_pc            fetched instruction and its address
//   instr_valid, instr_ready   downstream handshake
//   busy                       high in any state except IDLE
module instruction_fetch #(
    parameter int                 ADDR_W      = 8,
    parameter int                 DATA_W      = 8,
    parameter int                 PROG_LEN    = 128,
    parameter logic [ADDR_W-1:0]  START_ADDR  = '0,
    parameter logic [DATA_W-1:0]  HALT_OPCODE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_enable,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);
    localparam logic [31:0]       PLEN    = 32'(PROG_LEN);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] jump_tgt;
    logic              hs;

    // Wrap at the end of the program rather than at the address width.
    assign pc_inc   = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
    // Out-of-range jump targets fold back into the program.
    assign jump_tgt = ADDR_W'(32'(jump_addr) % PLEN);

    assign mem_address = pc_q;
    assign mem_enable  = (state_q == FETCH);
    assign instr_valid = (state_q == HOLD);
    assign busy        = (state_q != IDLE);
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign hs          = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        unique case (state_q)
            IDLE: begin
                // start beats a simultaneous halt; halt/jump are no-ops here
                if (start) begin
                    pc_d    = START_ADDR;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (halt) begin
                    state_d = IDLE;
                end else begin
                    // a jump still captures the word at the current PC
                    instr_d = mem_data;
                    ipc_d   = pc_q;
                    pc_d    = jump_en ? jump_tgt : pc_inc;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (halt) begin
                    state_d = IDLE;
                end else begin
                    if (jump_en) begin
                        pc_d = jump_tgt;
                    end
                    if (hs) begin
                        state_d = (instr_q == HALT_OPCODE) ? IDLE : FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch.
// Expected (instr, pc) pairs are queued with stimulus, popped on handshakes.
module tb_instruction_fetch;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       halt;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic [7:0] mem_address;
    logic       mem_enable;
    logic [7:0] mem_data;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       busy;

    logic [7:0]  mem [0:255];
    logic [15:0] sb_q[$];
    int          n_tests;
    int          n_fail;
    int          cnt;

    instruction_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt        (halt),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .mem_address (mem_address),
        .mem_enable  (mem_enable),
        .mem_data    (mem_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .busy        (busy)
    );

    assign mem_data = mem[mem_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] ins, input logic [7:0] pc);
        sb_q.push_back({ins, pc});
    endtask

    // Handshake at the next edge: valid & ready seen mid-cycle, no halt.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !halt) begin
            if (sb_q.size() == 0) begin
                chk("hs_unexpected", 32'd1, 32'd0);
            end else begin
                logic [15:0] e;
                e = sb_q.pop_front();
                chk("hs_instr", 32'(instr), 32'(e[15:8]));
                chk("hs_pc", 32'(instr_pc), 32'(e[7:0]));
            end
        end
    end

    task automatic run_prog();
        push(8'h02, 8'd0);
        push(8'h02, 8'd1);
        push(8'h03, 8'd2);
        push(8'h03, 8'd3);
        push(8'hFF, 8'd4);
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fetch_lat_en", 32'(mem_enable), 32'd1);
        chk("fetch_lat_addr", 32'(mem_address), 32'd0);
        cnt = 1;
        while (busy && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("prog_cycles", 32'(cnt), 32'd11);
        chk("prog_idle_busy", 32'(busy), 32'd0);
        chk("prog_sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(8'h10 + i);
        mem[0] = 8'h02;
        mem[1] = 8'h02;
        mem[2] = 8'h03;
        mem[3] = 8'h03;
        mem[4] = 8'hFF;
        rst_n = 1'b0;
        start = 1'b0;
        halt = 1'b0;
        jump_en = 1'b0;
        jump_addr = '0;
        instr_ready = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_men", 32'(mem_enable), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_ipc", 32'(instr_pc), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_after_rst", 32'(busy), 32'd0);

        // basic program to halt opcode
        run_prog();

        // stall with instr=2 at pc=1, then halt in HOLD
        instr_ready = 1'b0;
        push(8'h02, 8'd0);
        push(8'h02, 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_instr", 32'(instr), 32'h02);
            chk("stall_pc", 32'(instr_pc), 32'd1);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("stall_next_en", 32'(mem_enable), 32'd1);
        chk("stall_next_addr", 32'(mem_address), 32'd2);
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_busy", 32'(busy), 32'd0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_enable) cnt++;
            tick();
        end
        chk("halt_no_fetch", 32'(cnt), 32'd0);
        chk("halt_sb_empty", 32'(sb_q.size()), 32'd0);

        // jump during fetch of address 3
        push(8'h02, 8'd0);
        push(8'h02, 8'd1);
        push(8'h03, 8'd2);
        push(8'h03, 8'd3);
        push(8'h02, 8'd0);
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("jmp_f3_en", 32'(mem_enable), 32'd1);
        chk("jmp_f3_addr", 32'(mem_address), 32'd3);
        jump_en = 1'b1;
        jump_addr = 8'd0;
        tick();
        jump_en = 1'b0;
        chk("jmp_instr", 32'(instr), 32'h03);
        chk("jmp_ipc", 32'(instr_pc), 32'd3);
        chk("jmp_pc", 32'(mem_address), 32'd0);
        tick();
        chk("jmp_fetch_addr", 32'(mem_address), 32'd0);
        chk("jmp_fetch_en", 32'(mem_enable), 32'd1);
        tick();
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("jmp_halt_busy", 32'(busy), 32'd0);
        chk("jmp_sb_empty", 32'(sb_q.size()), 32'd0);

        // wrap at PC=127, then modulo jump target
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        jump_en = 1'b1;
        jump_addr = 8'd127;
        tick();
        jump_en = 1'b0;
        push(8'h02, 8'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("wrap_f127", 32'(mem_address), 32'd127);
        tick();
        chk("wrap_pc0", 32'(mem_address), 32'd0);
        push(mem[127], 8'd127);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("wrap_fetch_en", 32'(mem_enable), 32'd1);
        chk("wrap_fetch_addr", 32'(mem_address), 32'd0);
        jump_en = 1'b1;
        jump_addr = 8'd200;
        tick();
        jump_en = 1'b0;
        chk("jmp_mod", 32'(mem_address), 32'd72);
        halt = 1'b1;
        tick();
        chk("wrap_halt_busy", 32'(busy), 32'd0);

        // halt/jump ignored in IDLE; start beats halt
        jump_en = 1'b1;
        jump_addr = 8'd5;
        tick();
        jump_en = 1'b0;
        chk("idle_ign_busy", 32'(busy), 32'd0);
        chk("idle_ign_pc", 32'(mem_address), 32'd72);
        start = 1'b1;
        tick();
        start = 1'b0;
        halt = 1'b0;
        chk("start_win_busy", 32'(busy), 32'd1);
        chk("start_win_addr", 32'(mem_address), 32'd0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_valid", 32'(instr_valid), 32'd1);
        chk("busy_start_addr", 32'(mem_address), 32'd1);

        // async reset mid-HOLD
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_instr", 32'(instr), 32'd0);
        chk("arst_ipc", 32'(instr_pc), 32'd0);
        chk("arst_addr", 32'(mem_address), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst_idle", 32'(busy), 32'd0);
        run_prog();

        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
